axis_packet_buffer: RTL and testbench

- Store-and-forward buffer placed directly downstream of the packetizer stage.
- Accepts tlast-delimited AXI-Stream packets into internal memory.
- Presents a packet on the master side only after its last beat has been written, so the downstream DMA sees gap-free packets.
- Reports the number of complete packets held.

---
 rtl/axis_packet_buffer.sv | 72 +++++++
 tb/tb_axis_packet_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_buffer.sv
// axis_packet_buffer: store-and-forward AXI-Stream buffer that presents a packet only once its tlast is stored.
// Define AXIS_PACKET_BUFFER_DROP_EN to drop packets that overflow the buffer instead of backpressuring.
module axis_packet_buffer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [ADDR_WIDTH:0]         sts_pkt_count,
  output logic [31:0]                 sts_drop_count
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [AXIS_TDATA_WIDTH:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0] wr_ptr, wr_commit, rd_ptr, fill;
  logic full, wr_en, drop_start, commit, load, pop;
  assign fill = wr_ptr - rd_ptr;
  assign full = fill == DEPTH;
  assign commit = wr_en && s_axis_tlast;
  assign load = rd_ptr != wr_commit && (!m_axis_tvalid || m_axis_tready);
  assign pop = m_axis_tvalid && m_axis_tready && m_axis_tlast;
`ifdef AXIS_PACKET_BUFFER_DROP_EN
  logic drop;
  assign s_axis_tready = 1'b1;
  assign wr_en = s_axis_tvalid && !drop && !full;
  assign drop_start = s_axis_tvalid && !drop && full;
  // drop state swallows everything through the next tlast, which is counted once
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      drop <= 1'b0;
      sts_drop_count <= '0;
    end else if (s_axis_tvalid && (drop || full)) begin
      drop <= !s_axis_tlast;
      if (s_axis_tlast && sts_drop_count != '1) sts_drop_count <= sts_drop_count + 1;
    end
`else
  assign s_axis_tready = !full;
  assign wr_en = s_axis_tvalid && !full;
  assign drop_start = 1'b0;
  assign sts_drop_count = '0;
`endif
  always_ff @(posedge aclk)
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
  // rd_ptr never passes wr_commit, so uncommitted beats are never presented
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_ptr <= '0;
      wr_commit <= '0;
      rd_ptr <= '0;
      sts_pkt_count <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tdata <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      else if (drop_start) wr_ptr <= wr_commit;
      if (commit) wr_commit <= wr_ptr + 1'b1;
      if (commit != pop) sts_pkt_count <= commit ? sts_pkt_count + 1'b1 : sts_pkt_count - 1'b1;
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
        m_axis_tvalid <= 1'b1;
        {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_axis_packet_buffer.sv
// tb_axis_packet_buffer: randomized scoreboard bench for axis_packet_buffer at ADDR_WIDTH=4.
module tb_axis_packet_buffer;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef AXIS_PACKET_BUFFER_DROP_EN
  localparam int LIM = 14;
`else
  localparam int LIM = 1 << 30;
`endif
  logic aclk = 1'b0, aresetn = 1'b0;
  logic s_axis_tready, s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
  logic m_axis_tready = 1'b0, m_axis_tvalid, m_axis_tlast;
  logic [AW:0] sts_pkt_count;
  logic [31:0] sts_drop_count;
  always #5 aclk = ~aclk;
  axis_packet_buffer #(.AXIS_TDATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .sts_pkt_count(sts_pkt_count), .sts_drop_count(sts_drop_count)
  );
  int vectors = 0, errors = 0;
  int exp_cnt = 0, exp_drop = 0, acc_beats = 0, out_beats = 0;
  logic [DW:0] exp_q[$], cur[$];
  bit ignore = 0, hold = 0, acc = 0;
  logic [DW+1:0] held;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one clock cycle: drive at negedge, sample and update the packet-level model before the next posedge
  task automatic cyc(input bit sv, input logic [DW-1:0] sd, input bit sl, input bit mr);
    logic [DW:0] e;
    @(negedge aclk);
    s_axis_tvalid = sv;
    s_axis_tdata = sd;
    s_axis_tlast = sl;
    m_axis_tready = mr;
    #1;
    chk("pkt_count", 64'(sts_pkt_count), 64'(exp_cnt));
    chk("drop_count", 64'(sts_drop_count), 64'(exp_drop));
    if (hold) chk("stable", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'(held));
    if (m_axis_tvalid && mr) begin
      out_beats++;
      chk("out_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(e));
        if (e[DW]) exp_cnt--;
      end
    end
    hold = m_axis_tvalid && !mr;
    held = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
    acc = sv && s_axis_tready;
    if (acc && !ignore) begin
      acc_beats++;
      cur.push_back({sl, sd});
      if (sl) begin
        foreach (cur[i]) exp_q.push_back(cur[i]);
        cur.delete();
        exp_cnt++;
      end
    end
  endtask
  task automatic do_reset();
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    exp_q.delete();
    cur.delete();
    exp_cnt = 0;
    exp_drop = 0;
    acc_beats = 0;
    out_beats = 0;
    hold = 0;
    ignore = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask
  task automatic send_beat(input logic [DW-1:0] d, input bit l, input int pv, input int pr);
    int n = 0;
    do begin
      cyc(($urandom_range(99) < pv) && (acc_beats - out_beats < LIM), d, l, $urandom_range(99) < pr);
      n++;
    end while (!acc && n < 1000);
    chk("send_accepted", 64'(acc), 64'd1);
  endtask
  task automatic drain(input int pr);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cyc(0, '0, 0, $urandom_range(99) < pr);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 1);
    chk("drained", 64'(exp_q.size()), 64'd0);
    chk("idle_valid", 64'(m_axis_tvalid), 64'd0);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    do_reset();
    #1;
    chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_count", 64'(sts_pkt_count), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd1);
    // single 4-beat packet: valid two cycles after tlast, then back-to-back
    for (int i = 0; i < 4; i++) cyc(1, 32'h11 + i, i == 3, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, '0, 0, 1);
      chk("lat_valid", 64'(m_axis_tvalid), 64'(i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) chk("lat_data", 64'(m_axis_tdata), 64'(32'h11 + i - 1));
    end
    // two packets stored while stalled, then released with random tready
    for (int i = 0; i < 3; i++) cyc(1, 32'h20 + i, i == 2, 0);
    cyc(1, 32'h30, 1, 0);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    chk("two_pkts", 64'(sts_pkt_count), 64'd2);
    drain(50);
    // fill all 16 slots without tlast
    for (int i = 0; i < 16; i++) begin
      cyc(1, 32'h100 + i, 0, 0);
      chk("fill_accept", 64'(acc), 64'd1);
    end
`ifdef AXIS_PACKET_BUFFER_DROP_EN
    cur.delete();
    ignore = 1;
    for (int i = 16; i < 20; i++) begin
      cyc(1, 32'h100 + i, i == 19, 0);
      chk("drop_tready", 64'(s_axis_tready), 64'd1);
    end
    exp_drop = 1;
    ignore = 0;
    chk("drop_mvalid", 64'(m_axis_tvalid), 64'd0);
    for (int i = 0; i < 16; i++) cyc(1, 32'h300 + i, i == 15, 1);
    drain(100);
`else
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h110, 1, 1);
      chk("full_tready", 64'(s_axis_tready), 64'd0);
      chk("full_mvalid", 64'(m_axis_tvalid), 64'd0);
    end
`endif
    do_reset();
    // concurrent random streaming
    for (int p = 0; p < 1000; p++) begin
      int len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) send_beat($urandom, b == len - 1, 70, 70);
    end
    drain(70);
    // asynchronous reset mid-packet on both sides
    cyc(1, 32'h40, 0, 0);
    cyc(1, 32'h41, 1, 0);
    cyc(1, 32'h50, 0, 0);
    cyc(1, 32'h51, 0, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("arst_last", 64'(m_axis_tlast), 64'd0);
    chk("arst_data", 64'(m_axis_tdata), 64'd0);
    chk("arst_count", 64'(sts_pkt_count), 64'd0);
    do_reset();
    cyc(1, 32'h60, 0, 1);
    cyc(1, 32'h61, 1, 1);
    drain(100);
    // pointer wrap: 40 packets of 3 beats
    for (int p = 0; p < 40; p++)
      for (int b = 0; b < 3; b++) send_beat(32'h1000 + p * 4 + b, b == 2, 100, 100);
    drain(100);
    chk("wrap_count", 64'(sts_pkt_count), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
